// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry constants and FSM state type for the 2-way set-associative cache controller
package cache_pkg;
  localparam int TAG_W  = 4;
  localparam int LINE_W = 1;
  localparam int OFF_W  = 3;
  localparam int DATA_W = 8;
  localparam int ADDR_W = TAG_W + LINE_W + OFF_W;
  localparam int NLINES = 1 << LINE_W;
  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;
endpackage

// File: rtl/cache_tag_store.sv
// cache_tag_store: tag/valid/lru registers with combinational hit compare and victim selection
// Ports: clk, reset (async, active-high); line/tag = lookup key; inv clears valid[line][way];
//   fill installs tag and sets valid[line][way]; touch sets lru[line] = ~way;
//   hit/hit_way = lookup result (way 0 wins); victim = first invalid way, else lru[line].
module cache_tag_store import cache_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic [LINE_W-1:0] line,
  input  logic [TAG_W-1:0]  tag,
  input  logic              inv,
  input  logic              fill,
  input  logic              touch,
  input  logic              way,
  output logic              hit,
  output logic              hit_way,
  output logic              victim
);
  logic [NLINES-1:0][1:0][TAG_W-1:0] tags;
  logic [NLINES-1:0][1:0]            valid;
  logic [NLINES-1:0]                 lru;
  logic                              h0, h1;
  always_comb begin
    h0      = valid[line][0] && tags[line][0] == tag;
    h1      = valid[line][1] && tags[line][1] == tag;
    hit     = h0 | h1;
    hit_way = ~h0;
    victim  = !valid[line][0] ? 1'b0 : !valid[line][1] ? 1'b1 : lru[line];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tags  <= '0;
      valid <= '0;
      lru   <= '0;
    end else begin
      if (inv) valid[line][way] <= 1'b0;
      if (fill) begin
        tags[line][way]  <= tag;
        valid[line][way] <= 1'b1;
      end
      if (touch) lru[line] <= ~way;
    end
  end
endmodule

// File: rtl/cache_set_assoc_ctrl.sv
// cache_set_assoc_ctrl: read-only 2-way set-associative cache controller with byte-wise refill from memory
// Ports: clk, reset (async, active-high); CPU side req_valid/req_addr/req_ready, resp_valid/resp_data/resp_hit;
//   memory side mem_req/mem_addr/mem_ack/mem_rdata; data array side rd*/wr*/wren/wdata/cache_q.
// Optional: define CACHE_STATS_EN to add saturating 16-bit hit_cnt/miss_cnt outputs.
module cache_set_assoc_ctrl import cache_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [LINE_W-1:0] rdline,
  output logic [OFF_W-1:0]  rdoffset,
  output logic              rdentry,
  output logic [LINE_W-1:0] wrline,
  output logic [OFF_W-1:0]  wroffset,
  output logic              wrentry,
  output logic              wren,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] cache_q
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);
  state_t             state, state_nx;
  logic [ADDR_W-1:0]  addr_q;
  logic [TAG_W-1:0]   tag_q;
  logic [LINE_W-1:0]  line_q;
  logic [OFF_W-1:0]   off_q;
  logic [OFF_W-1:0]   fill_cnt;
  logic               way_q, hit_q, hit, hit_way, victim, last;
  assign {tag_q, line_q, off_q} = addr_q;
  cache_tag_store u_tags (
    .clk     (clk),
    .reset   (reset),
    .line    (line_q),
    .tag     (tag_q),
    .inv     (state == LOOKUP && !hit),
    .fill    (last),
    .touch   (state == RESP),
    .way     (state == LOOKUP ? victim : way_q),
    .hit     (hit),
    .hit_way (hit_way),
    .victim  (victim)
  );
  always_comb begin
    last       = state == FILL && mem_ack && fill_cnt == '1;
    state_nx   = state == IDLE   ? (req_valid ? LOOKUP : IDLE) :
                 state == LOOKUP ? (hit ? RESP : FILL) :
                 state == FILL   ? (last ? RESP : FILL) : IDLE;
    req_ready  = state == IDLE;
    resp_valid = state == RESP;
    resp_data  = resp_valid ? cache_q : '0;
    resp_hit   = resp_valid && hit_q;
    mem_req    = state == FILL;
    mem_addr   = mem_req ? {tag_q, line_q, fill_cnt} : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      way_q    <= 1'b0;
      hit_q    <= 1'b0;
      fill_cnt <= '0;
      wren     <= 1'b0;
      wdata    <= '0;
      wrline   <= '0;
      wroffset <= '0;
      wrentry  <= 1'b0;
      rdline   <= '0;
      rdoffset <= '0;
      rdentry  <= 1'b0;
    end else begin
      state <= state_nx;
      wren  <= state == FILL && mem_ack;
      if (state == IDLE && req_valid) addr_q <= req_addr;
      if (state == LOOKUP) begin
        hit_q    <= hit;
        way_q    <= hit ? hit_way : victim;
        fill_cnt <= '0;
      end
      if (state == LOOKUP && hit) {rdline, rdoffset, rdentry} <= {line_q, off_q, hit_way};
      if (state == FILL && mem_ack) begin
        {wrline, wroffset, wrentry, wdata} <= {line_q, fill_cnt, way_q, mem_rdata};
        fill_cnt <= fill_cnt + OFF_W'(1);
      end
      if (last) {rdline, rdoffset, rdentry} <= {line_q, off_q, way_q};
    end
  end
`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == RESP) begin
      if (hit_q && hit_cnt != '1) hit_cnt <= hit_cnt + 16'd1;
      if (!hit_q && miss_cnt != '1) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_set_assoc_ctrl.sv
// tb_cache_set_assoc_ctrl: directed self-checking bench with behavioural memory and data array models
module tb_cache_set_assoc_ctrl;
  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_ready;
  logic [7:0]  req_addr = '0, resp_data, mem_addr, mem_rdata = '0, wdata, cache_q = '0;
  logic        resp_valid, resp_hit, mem_req, mem_ack = 1'b0;
  logic        rdline, rdentry, wrline, wrentry, wren;
  logic [2:0]  rdoffset, wroffset;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif
  int          checks = 0, errors = 0;
  int          wren_cnt = 0, ack_cnt = 0, memreq_cnt = 0, unstable_cnt = 0, wait_cnt = 0, ack_delay = 0;
  logic [12:0] wr_log [0:255];
  logic [7:0]  ack_log [0:255];
  logic [7:0]  arr [0:1][0:1][0:7];
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [7:0]  prev_addr = '0;
  always #5 clk = ~clk;
  cache_set_assoc_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rdline(rdline), .rdoffset(rdoffset), .rdentry(rdentry),
    .wrline(wrline), .wroffset(wroffset), .wrentry(wrentry),
    .wren(wren), .wdata(wdata), .cache_q(cache_q)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );
  function automatic logic [7:0] mem_fn(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction
  always @(negedge clk) begin
    if (wren) arr[wrline][wrentry][wroffset] = wdata;
    cache_q = arr[rdline][rdentry][rdoffset];
  end
  always @(negedge clk) begin
    if (mem_ack) mem_ack = 1'b0;
    else if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_rdata = mem_fn(mem_addr);
        mem_ack = 1'b1;
        ack_log[8'(ack_cnt)] = mem_addr;
        ack_cnt++;
        wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end
  always @(negedge clk) begin
    #2;
    if (wren) begin
      wr_log[8'(wren_cnt)] = {wrentry, wrline, wroffset, wdata};
      wren_cnt++;
    end
    if (mem_req) memreq_cnt++;
    if (mem_req && prev_req && !prev_ack && mem_addr != prev_addr) unstable_cnt++;
    prev_req = mem_req;
    prev_ack = mem_ack;
    prev_addr = mem_addr;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_outs"}, 64'({resp_valid, resp_data, resp_hit, mem_req, mem_addr, wren, wdata,
                             rdline, rdoffset, rdentry, wrline, wroffset, wrentry}), 64'd0);
  endtask
  task automatic do_read(input logic [7:0] a, output logic [7:0] d, output logic h, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = a;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    d = '0;
    h = 1'b0;
    for (int n = 1; n <= 300 && lat == 0; n++) begin
      @(negedge clk);
      #3;
      if (resp_valid) begin
        lat = n;
        d = resp_data;
        h = resp_hit;
      end
    end
    chk("resp_seen", 64'(lat != 0), 64'd1);
  endtask
  task automatic fill_check(input logic [7:0] base, input logic line, input logic way, input int w0, input int a0);
    for (int i = 0; i < 8; i++) begin
      chk("fill_wr", 64'(wr_log[8'(w0 + i)]), 64'({way, line, 3'(i), mem_fn(base + 8'(i))}));
      chk("fill_addr", 64'(ack_log[8'(a0 + i)]), 64'(base + 8'(i)));
    end
  endtask
  initial begin
    logic [7:0] d;
    logic       h;
    int         lat, w0, a0, m0, u0;
    repeat (2) @(negedge clk);
    #1 chk_reset("reset");
    reset = 1'b0;
    w0 = wren_cnt; a0 = ack_cnt;
    do_read(8'h25, d, h, lat);
    chk("m25_hit", 64'(h), 64'd0);
    chk("m25_data", 64'(d), 64'(mem_fn(8'h25)));
    chk("m25_wren", 64'(wren_cnt - w0), 64'd8);
    fill_check(8'h20, 1'b0, 1'b0, w0, a0);
    w0 = wren_cnt; m0 = memreq_cnt;
    do_read(8'h23, d, h, lat);
    chk("h23_lat", 64'(lat), 64'd2);
    chk("h23_hit", 64'(h), 64'd1);
    chk("h23_data", 64'(d), 64'(mem_fn(8'h23)));
    chk("h23_memreq", 64'(memreq_cnt - m0), 64'd0);
    chk("h23_wren", 64'(wren_cnt - w0), 64'd0);
    do_read(8'h25, d, h, lat);
    chk("h25_hit", 64'(h), 64'd1);
    w0 = wren_cnt; a0 = ack_cnt;
    do_read(8'h45, d, h, lat);
    chk("m45_hit", 64'(h), 64'd0);
    chk("m45_data", 64'(d), 64'(mem_fn(8'h45)));
    fill_check(8'h40, 1'b0, 1'b1, w0, a0);
    w0 = wren_cnt; a0 = ack_cnt;
    do_read(8'h65, d, h, lat);
    chk("m65_hit", 64'(h), 64'd0);
    chk("m65_data", 64'(d), 64'(mem_fn(8'h65)));
    fill_check(8'h60, 1'b0, 1'b0, w0, a0);
    do_read(8'h45, d, h, lat);
    chk("h45_hit", 64'(h), 64'd1);
    chk("h45_lat", 64'(lat), 64'd2);
    chk("h45_data", 64'(d), 64'(mem_fn(8'h45)));
    ack_delay = 3;
    w0 = wren_cnt; a0 = ack_cnt; u0 = unstable_cnt;
    do_read(8'hB9, d, h, lat);
    chk("slow_hit", 64'(h), 64'd0);
    chk("slow_data", 64'(d), 64'(mem_fn(8'hB9)));
    chk("slow_wren", 64'(wren_cnt - w0), 64'd8);
    chk("slow_acks", 64'(ack_cnt - a0), 64'd8);
    chk("slow_stable", 64'(unstable_cnt - u0), 64'd0);
    fill_check(8'hB8, 1'b1, 1'b0, w0, a0);
    ack_delay = 0;
    w0 = wren_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 8'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 100 && wren_cnt - w0 < 4; i++) begin
      @(negedge clk);
      #3;
    end
    chk("mid_bytes", 64'(wren_cnt - w0), 64'd4);
    reset = 1'b1;
    #1 chk_reset("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    w0 = wren_cnt; a0 = ack_cnt;
    do_read(8'h5A, d, h, lat);
    chk("r5A_hit", 64'(h), 64'd0);
    chk("r5A_data", 64'(d), 64'(mem_fn(8'h5A)));
    chk("r5A_wren", 64'(wren_cnt - w0), 64'd8);
    fill_check(8'h58, 1'b1, 1'b0, w0, a0);
    do_read(8'h23, d, h, lat);
    chk("r23_hit", 64'(h), 64'd0);
    chk("r23_data", 64'(d), 64'(mem_fn(8'h23)));
    do_read(8'h5A, d, h, lat);
    chk("h5A_hit", 64'(h), 64'd1);
    chk("h5A_lat", 64'(lat), 64'd2);
    do_read(8'h23, d, h, lat);
    chk("h23b_hit", 64'(h), 64'd1);
    w0 = wren_cnt; a0 = ack_cnt;
    do_read(8'h45, d, h, lat);
    chk("m45b_hit", 64'(h), 64'd0);
    fill_check(8'h40, 1'b0, 1'b1, w0, a0);
`ifdef CACHE_STATS_EN
    chk("stat_hits", 64'(hit_cnt), 64'd2);
    chk("stat_misses", 64'(miss_cnt), 64'd3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
